// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: address type, block width,
// I/O window and FSM state encoding.
package mem_ctrl_pkg;

    localparam int ADDR_W                 = 32;
    localparam int ICACHE_INST_BLOCK_SIZE = 128;
    localparam int FETCH_BYTES            = ICACHE_INST_BLOCK_SIZE / 8;

    typedef logic [ADDR_W-1:0] addr_t;

    // I/O window is 0x30000..0x3FFFF: upper half-word equal to 0x0003
    localparam addr_t IO_BASE      = 32'h0003_0000;
    localparam addr_t IO_SPAN_MASK = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } state_t;

    function automatic logic is_io(input addr_t a);
        return (a & IO_SPAN_MASK) == IO_BASE;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating between instruction fetch (16-byte
// blocks) and load/store unit accesses, with rollback and I/O back-pressure.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rdy,
    input  logic [7:0]                        mem_din,
    output logic [7:0]                        mem_dout,
    output addr_t                             mem_a,
    output logic                              mem_wr,
    input  logic                              io_buffer_full,
    input  logic                              ifetch_en,
    input  addr_t                             ifetch_addr,
    input  logic                              ifetch_rollback,
    output logic                              ifetch_finish,
    output logic [ICACHE_INST_BLOCK_SIZE-1:0] ifetch_block,
    input  logic                              lsb_en,
    input  logic                              lsb_wr,
    input  addr_t                             lsb_addr,
    input  logic [2:0]                        lsb_size,
    input  logic [31:0]                       lsb_wdata,
    output logic                              lsb_finish,
    output logic [31:0]                       lsb_rdata,
    input  logic                              rob_rollback,
    output state_t                            fsm_state
);

    state_t                            state, state_nx;
    logic [4:0]                        cnt;
    logic [4:0]                        len;
    addr_t                             base;
    logic [31:0]                       wdata;
    logic [ICACHE_INST_BLOCK_SIZE-1:0] asm_q, asm_nx;
    logic                              rdy_q;
    logic [7:0]                        din_q, din_byte;
    logic [3:0]                        cap_idx;

    logic   fin_busy, accept_lsb, accept_if;
    logic   rd_abort, rd_done, rd_issue, rd_capture;
    addr_t  st_base, st_a;
    logic [4:0]  st_idx;
    logic [31:0] st_data;
    logic [7:0]  st_byte;
    logic   st_stall, st_done;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_lsb)
                    state_nx = lsb_wr ? STORE : LOAD;
                else if (accept_if)
                    state_nx = IFETCH;
            end
            IFETCH, LOAD: begin
                if (rd_abort || rd_done)
                    state_nx = IDLE;
            end
            STORE: begin
                if (st_done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        // No acceptance while a finish is showing: requesters still hold enable then
        fin_busy   = ifetch_finish | lsb_finish;
        accept_lsb = lsb_en & ~rob_rollback & ~fin_busy;
        accept_if  = ifetch_en & ~lsb_en & ~rob_rollback & ~ifetch_rollback & ~fin_busy;

        rd_abort   = rob_rollback | ((state == IFETCH) & ifetch_rollback);
        rd_done    = (cnt == len + 5'd1);
        rd_issue   = (cnt < len);
        rd_capture = (cnt >= 5'd2);

        // In IDLE the first store byte is issued straight from the request
        st_base  = (state == IDLE) ? lsb_addr : base;
        st_idx   = (state == IDLE) ? 5'd0 : cnt;
        st_data  = (state == IDLE) ? lsb_wdata : wdata;
        st_a     = st_base + {27'd0, st_idx};
        st_byte  = st_data[{st_idx[1:0], 3'b000} +: 8];
        st_stall = is_io(st_a) & io_buffer_full;
        st_done  = (cnt == len);

        // After an rdy stall the RAM has moved on; the wanted byte sits in din_q
        din_byte = rdy_q ? mem_din : din_q;
        cap_idx  = cnt[3:0] - 4'd2;
        asm_nx   = asm_q;
        asm_nx[{cap_idx, 3'b000} +: 8] = din_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b1;
            din_q <= 8'd0;
        end else begin
            rdy_q <= rdy;
            din_q <= din_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 5'd0;
            len           <= 5'd0;
            base          <= '0;
            wdata         <= 32'd0;
            asm_q         <= '0;
            mem_a         <= '0;
            mem_dout      <= 8'd0;
            mem_wr        <= 1'b0;
            ifetch_finish <= 1'b0;
            lsb_finish    <= 1'b0;
            ifetch_block  <= '0;
            lsb_rdata     <= 32'd0;
        end else if (rdy) begin
            mem_a         <= '0;
            mem_wr        <= 1'b0;
            ifetch_finish <= 1'b0;
            lsb_finish    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_lsb) begin
                        base  <= lsb_addr;
                        len   <= {2'b00, lsb_size};
                        wdata <= lsb_wdata;
                        asm_q <= '0;
                        if (lsb_wr) begin
                            if (!st_stall) begin
                                mem_a    <= st_a;
                                mem_dout <= st_byte;
                                mem_wr   <= 1'b1;
                                cnt      <= 5'd1;
                            end else begin
                                cnt <= 5'd0;
                            end
                        end else begin
                            mem_a <= lsb_addr;
                            cnt   <= 5'd1;
                        end
                    end else if (accept_if) begin
                        base  <= ifetch_addr;
                        len   <= 5'(FETCH_BYTES);
                        asm_q <= '0;
                        mem_a <= ifetch_addr;
                        cnt   <= 5'd1;
                    end
                end
                IFETCH, LOAD: begin
                    if (rd_abort) begin
                        cnt <= 5'd0;
                    end else begin
                        if (rd_issue)
                            mem_a <= base + {27'd0, cnt};
                        if (rd_capture)
                            asm_q <= asm_nx;
                        if (rd_done) begin
                            cnt <= 5'd0;
                            if (state == IFETCH) begin
                                ifetch_finish <= 1'b1;
                                ifetch_block  <= asm_nx;
                            end else begin
                                lsb_finish <= 1'b1;
                                lsb_rdata  <= asm_nx[31:0];
                            end
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                STORE: begin
                    // Stores are committed: rollback is deliberately ignored here
                    if (st_done) begin
                        lsb_finish <= 1'b1;
                        cnt        <= 5'd0;
                    end else if (!st_stall) begin
                        mem_a    <= st_a;
                        mem_dout <= st_byte;
                        mem_wr   <= 1'b1;
                        cnt      <= cnt + 5'd1;
                    end
                end
                default: cnt <= 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized bench for mem_ctrl: a synchronous RAM model on the
// memory port and a byte-level reference memory for expected read data.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst, rdy;
    logic [7:0]   mem_din, mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr, io_buffer_full;
    logic         ifetch_en, ifetch_rollback, ifetch_finish;
    logic [31:0]  ifetch_addr;
    logic [127:0] ifetch_block;
    logic         lsb_en, lsb_wr, lsb_finish;
    logic [31:0]  lsb_addr, lsb_wdata, lsb_rdata;
    logic [2:0]   lsb_size;
    logic         rob_rollback;
    state_t       fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  ram_w [logic [31:0]];
    logic [7:0]  ref_w [logic [31:0]];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .ifetch_en(ifetch_en), .ifetch_addr(ifetch_addr), .ifetch_rollback(ifetch_rollback),
        .ifetch_finish(ifetch_finish), .ifetch_block(ifetch_block),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_finish(lsb_finish), .lsb_rdata(lsb_rdata),
        .rob_rollback(rob_rollback), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_w.exists(a)) return ram_w[a];
        return a[7:0];
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_w.exists(a)) return ref_w[a];
        return a[7:0];
    endfunction

    // Synchronous RAM: data for the address seen on one edge appears after it
    always @(posedge clk) begin
        if (mem_wr) ram_w[mem_a] = mem_dout;
        mem_din <= ram_rd(mem_a);
    end

    function automatic bit in_io(input logic [31:0] a);
        return (a >= 32'h0003_0000) && (a <= 32'h0003_FFFF);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_fin(input bit fetch);
        return fetch ? ifetch_finish : lsb_finish;
    endfunction

    // Read transaction. Cycle 0 is the IDLE cycle holding the request. e counts
    // edges taken with rdy=1; outputs in a cycle follow from e alone.
    task automatic run_read(input bit fetch, input logic [31:0] base, input int n,
                            input int stall_from, input int stall_len,
                            input int rb_cycle, input bit rb_if, output int fin_cyc);
        int e = 0;
        bit done = 0;
        bit rdy_now;
        logic [127:0] exp_blk = '0;
        state_t busy = fetch ? IFETCH : LOAD;
        fin_cyc = -1;
        for (int k = 0; k < n; k++) exp_blk[8*k +: 8] = ref_rd(base + 32'(k));
        if (fetch) begin
            ifetch_en = 1'b1; ifetch_addr = base;
        end else begin
            lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = base; lsb_size = 3'(n);
        end
        for (int c = 0; c < 64 && !done; c++) begin
            rdy_now = !(c >= stall_from && c < stall_from + stall_len);
            rdy = rdy_now;
            if (c == rb_cycle) begin
                if (rb_if) ifetch_rollback = 1'b1;
                else rob_rollback = 1'b1;
            end
            tick();
            rdy = 1'b1; ifetch_rollback = 1'b0; rob_rollback = 1'b0;
            if (rdy_now) e++;
            if (c == rb_cycle) begin
                check("rb_state", fsm_state, IDLE);
                check("rb_fin", get_fin(fetch), 1'b0);
                check("rb_mem_a", mem_a, 32'd0);
                ifetch_en = 1'b0; lsb_en = 1'b0;
                repeat (2) begin
                    tick();
                    check("rb_no_fin", get_fin(fetch), 1'b0);
                    check("rb_idle", fsm_state, IDLE);
                end
                done = 1;
            end else begin
                check("rd_mem_a", mem_a, (e >= 1 && e <= n) ? base + 32'(e - 1) : 32'd0);
                check("rd_mem_wr", mem_wr, 1'b0);
                check("rd_fin", get_fin(fetch), (e == n + 2));
                check("rd_other_fin", get_fin(!fetch), 1'b0);
                check("rd_state", fsm_state, (e == n + 2) ? IDLE : busy);
                if (e == n + 2) begin
                    fin_cyc = c + 1;
                    if (fetch) check("fetch_block", ifetch_block, exp_blk);
                    else check("load_data", {96'd0, lsb_rdata}, exp_blk);
                    ifetch_en = 1'b0; lsb_en = 1'b0;
                    tick();
                    check("gap_state", fsm_state, IDLE);
                    check("gap_fin", get_fin(fetch), 1'b0);
                    done = 1;
                end
            end
        end
        if (!done) check("rd_timeout", 1'b0, 1'b1);
    endtask

    // Store transaction. io_mode: 0 never full, 1 full for cycles 0..2, 2 random.
    task automatic run_store(input logic [31:0] base, input int n, input logic [31:0] data,
                             input int io_mode, input int rb_cycle, output int fin_cyc);
        int k = 0;
        bit done = 0;
        logic io;
        logic [39:0] ex;
        fin_cyc = -1;
        for (int i = 0; i < n; i++) exp_q.push_back({base + 32'(i), data[8*i +: 8]});
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = base; lsb_size = 3'(n); lsb_wdata = data;
        for (int c = 0; c < 64 && !done; c++) begin
            io = (io_mode == 1) ? (c < 3) : (io_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            io_buffer_full = io;
            rob_rollback = (c == rb_cycle);
            tick();
            io_buffer_full = 1'b0; rob_rollback = 1'b0;
            if (k == n) begin
                fin_cyc = c + 1;
                check("st_fin", lsb_finish, 1'b1);
                check("st_done_wr", mem_wr, 1'b0);
                check("st_done_a", mem_a, 32'd0);
                check("st_done_state", fsm_state, IDLE);
                for (int i = 0; i < n; i++) ref_w[base + 32'(i)] = data[8*i +: 8];
                lsb_en = 1'b0; lsb_wr = 1'b0;
                tick();
                check("st_gap_state", fsm_state, IDLE);
                check("st_gap_fin", lsb_finish, 1'b0);
                done = 1;
            end else if (in_io(base + 32'(k)) && io) begin
                check("st_stall_wr", mem_wr, 1'b0);
                check("st_stall_a", mem_a, 32'd0);
                check("st_stall_fin", lsb_finish, 1'b0);
            end else begin
                check("st_wr", mem_wr, 1'b1);
                ex = exp_q.pop_front();
                check("st_write", {mem_a, mem_dout}, ex);
                check("st_fin_early", lsb_finish, 1'b0);
                k++;
            end
        end
        if (!done) check("st_timeout", 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 32'h0000_1000 + 32'($urandom_range(0, 47));
            1:       return 32'h0003_FFF0 + 32'($urandom_range(0, 31));
            default: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic int rand_size();
        case ($urandom_range(0, 2))
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int fc;
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
        ifetch_en = 1'b0; ifetch_addr = 32'd0; ifetch_rollback = 1'b0;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_size = 3'd0; lsb_wdata = 32'd0;
        rob_rollback = 1'b0;
        repeat (3) tick();
        check("rst_state", fsm_state, IDLE);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", mem_dout, 8'd0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_if_fin", ifetch_finish, 1'b0);
        check("rst_lsb_fin", lsb_finish, 1'b0);
        check("rst_block", ifetch_block, 128'd0);
        check("rst_rdata", lsb_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Fetch at 0x100 over the default byte pattern
        run_read(1, 32'h100, 16, -1, 0, -1, 0, fc);
        check("fetch100_cycle", fc, 18);
        check("fetch100_block", ifetch_block, 128'h0F0E0D0C0B0A09080706050403020100);

        // Store 0xDEADBEEF at 0x80
        run_store(32'h80, 4, 32'hDEADBEEF, 0, -1, fc);
        check("store80_cycle", fc, 5);

        // Simultaneous fetch and load: load first, fetch after one IDLE cycle
        ifetch_en = 1'b1; ifetch_addr = 32'h80;
        run_read(0, 32'h200, 4, -1, 0, -1, 0, fc);
        check("arb_load_cycle", fc, 6);
        run_read(1, 32'h80, 16, -1, 0, -1, 0, fc);
        check("arb_fetch_cycle", fc, 18);

        // I/O store stalled for three cycles
        run_store(32'h30000, 1, 32'h0000_005A, 1, -1, fc);
        check("io_store_cycle", fc, 5);

        // Rollbacks: fetch aborted, store unaffected, ifetch_rollback, load aborted
        run_read(1, 32'h200, 16, -1, 0, 7, 0, fc);
        run_store(32'h90, 4, 32'h1234_5678, 0, 2, fc);
        check("rb_store_cycle", fc, 5);
        run_read(1, 32'h300, 16, -1, 0, 3, 1, fc);
        run_read(0, 32'h84, 4, -1, 0, 2, 0, fc);

        // rdy low for 5 cycles mid-load
        run_read(0, 32'h80, 4, 2, 5, -1, 0, fc);
        check("stall_load_cycle", fc, 11);
        check("stall_load_data", lsb_rdata, 32'hDEADBEEF);

        // Rollback together with a request in IDLE drops it
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h40; lsb_size = 3'd4; rob_rollback = 1'b1;
        tick();
        lsb_en = 1'b0; rob_rollback = 1'b0;
        check("idle_rb_state", fsm_state, IDLE);
        check("idle_rb_mem_a", mem_a, 32'd0);
        tick();

        // Reset mid-fetch with rdy low
        ifetch_en = 1'b1; ifetch_addr = 32'h400;
        repeat (4) tick();
        rst = 1'b1; rdy = 1'b0;
        tick();
        rst = 1'b0; rdy = 1'b1; ifetch_en = 1'b0;
        check("midrst_state", fsm_state, IDLE);
        check("midrst_mem_a", mem_a, 32'd0);
        check("midrst_fin", ifetch_finish, 1'b0);
        repeat (20) begin
            tick();
            check("midrst_no_fin", ifetch_finish, 1'b0);
        end

        // Randomized mix against the reference memory
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: run_read(1, rand_addr() & 32'hFFFF_FFF0, 16, -1, 0, -1, 0, fc);
                1: begin
                    if ($urandom_range(0, 1) == 1)
                        run_read(0, rand_addr(), rand_size(), $urandom_range(2, 4),
                                 $urandom_range(0, 3), -1, 0, fc);
                    else
                        run_read(0, rand_addr(), rand_size(), -1, 0, -1, 0, fc);
                end
                default: run_store(rand_addr(), rand_size(), $urandom(), 2, -1, fc);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
